dmem_seq_reader: RTL



---
 rtl/localmem_pkg.sv | 7 +
 rtl/dmem_rd_fifo.sv | 40 ++++
 rtl/dmem_seq_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/localmem_pkg.sv
// localmem_pkg: shared dmem geometry, read latency and reader FSM states
package localmem_pkg;
  localparam int DM_ADDR = 8;
  localparam int DM_ARRAY_COLS = 32;
  localparam int DMEM_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;
endpackage

// File: rtl/dmem_rd_fifo.sv
// dmem_rd_fifo: first-word-fall-through buffer for samples returned by dmem
module dmem_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout = mem[rp];
  // storage needs no reset: an entry is only visible once count covers it
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/dmem_seq_reader.sv
// dmem_seq_reader: strided dmem read sequencer with credit-limited output FIFO
module dmem_seq_reader
  import localmem_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR,
  parameter int DATA_W = DM_ARRAY_COLS,
  parameter int CNT_W = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE,
  input  logic [ADDR_W-1:0] STRIDE,
  input  logic [CNT_W-1:0]  COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_MODE,
  output logic              MEM_WEB,
  output logic              MEM_OEB,
  output logic [ADDR_W-1:0] MEM_A,
  input  logic [DATA_W-1:0] MEM_SEQ_O,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, stride, a_hold;
  logic [CNT_W-1:0] len, issued;
  logic inflight, inflight_last, issue, last_issue, pop, empty, full;
  logic [CW-1:0] fcnt;
  logic [DATA_W:0] head;
  assign issue = state == RUN && !full &&
                 (CW+1)'(fcnt) + (CW+1)'(inflight) < (CW+1)'(FIFO_DEPTH);
  assign last_issue = issue && issued == len - CNT_W'(1);
  assign pop = OUT_VALID && OUT_READY;
  assign MEM_MODE = 1'b1;
  assign MEM_WEB = 1'b1;
  assign MEM_OEB = !issue;
  assign MEM_A = issue ? addr : a_hold;
  assign BUSY = state == RUN || state == DRAIN;
  assign DONE = state == DONE_ST;
  assign OUT_VALID = !empty;
  assign OUT_DATA = empty ? '0 : head[DATA_W-1:0];
  assign OUT_LAST = !empty && head[DATA_W];
  // next state; DRAIN exits as the final buffered beat handshakes
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (START) state_n = |COUNT ? RUN : DONE_ST;
      RUN: if (last_issue) state_n = DRAIN;
      DRAIN: if (!inflight && (empty || (pop && fcnt == CW'(1)))) state_n = DONE_ST;
      default: state_n = IDLE;
    endcase
  end
  // command registers, address walk and the one-deep read-in-flight flag
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      addr <= '0;
      stride <= '0;
      a_hold <= '0;
      len <= '0;
      issued <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= issue;
      inflight_last <= last_issue;
      if (state == IDLE && START) begin
        addr <= BASE;
        stride <= STRIDE;
        len <= COUNT;
        issued <= '0;
      end else if (issue) begin
        addr <= addr + stride;
        a_hold <= addr;
        issued <= issued + CNT_W'(1);
      end
    end
  dmem_rd_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push(inflight),
    .pop(pop),
    .din({inflight_last, MEM_SEQ_O}),
    .dout(head),
    .empty(empty),
    .full(full),
    .count(fcnt)
  );
endmodule
